// File: rtl/serial_adder_pkg.sv
// Shared types and sizing for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;
  localparam int unsigned SA_CNT_W         = $clog2(SA_DEFAULT_WIDTH);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned sa_cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_shreg.sv
// Right-shift register with parallel load; load takes priority over shift.
module serial_adder_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_in_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= {shift_in_i, q_q[W-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial addition sequencer driving an external full-adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned CNT_W = sa_cnt_w(WIDTH);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             load_c, shift_c, last_c, in_shift_c;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;

  serial_adder_shreg #(.W(WIDTH)) u_a_sh (
    .clk(clk), .rst_n(rst_n), .load_i(load_c), .shift_i(shift_c),
    .load_val_i(a_in), .shift_in_i(1'b0), .q_o(a_sh_q)
  );

  serial_adder_shreg #(.W(WIDTH)) u_b_sh (
    .clk(clk), .rst_n(rst_n), .load_i(load_c), .shift_i(shift_c),
    .load_val_i(b_in), .shift_in_i(1'b0), .q_o(b_sh_q)
  );

  serial_adder_shreg #(.W(WIDTH)) u_sum_sh (
    .clk(clk), .rst_n(rst_n), .load_i(load_c), .shift_i(shift_c),
    .load_val_i({WIDTH{1'b0}}), .shift_in_i(fa_sum), .q_o(sum_sh_q)
  );

  // Only the LSB of each operand and the upper sum bits are consumed here.
  logic unused_sh_bits;
  assign unused_sh_bits = ^{a_sh_q[WIDTH-1:1], b_sh_q[WIDTH-1:1], sum_sh_q[0]};

  assign in_shift_c = (state_q == SHIFT);
  assign last_c     = (cnt_q == CNT_W'(WIDTH - 1));

  assign fa_a   = in_shift_c & a_sh_q[0];
  assign fa_b   = in_shift_c & b_sh_q[0];
  assign fa_cin = in_shift_c & carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_c  = 1'b1;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // Final bit: publish the full result in one step, never partials.
        if (last_c) begin
          sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = fa_cin ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_out = ovf_q;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq with a behavioural full-adder cell.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout_out, fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic [W-1:0] sum_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_out;
`endif

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cin(cin), .busy(busy), .done(done), .sum_out(sum_out),
    .cout_out(cout_out), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_out(ovf_out)
`endif
  );

  // Full-adder cell that sits outside the sequencer.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   next_ok = 0;
  int   act_e0 = 0;
  bit   act = 1'b0;
  logic [W-1:0] held_s = '0;
  logic         held_c = 1'b0;
  logic         held_o = 1'b0;
  bit   bexp, dexp;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int due);
    exp_t r;
    int   ua, ub, sa, sb, tot, stot;
    ua   = int'(a);
    ub   = int'(b);
    tot  = ua + ub + int'(c);
    sa   = a[W-1] ? ua - (1 << W) : ua;
    sb   = b[W-1] ? ub - (1 << W) : ub;
    stot = sa + sb + int'(c);
    r.s   = W'(tot % (1 << W));
    r.c   = (tot >= (1 << W));
    r.o   = (stot > (1 << (W - 1)) - 1) || (stot < -(1 << (W - 1)));
    r.due = due;
    return r;
  endfunction

  // Request model: a start is taken unless a previous one is still within its W+1 cycle slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      next_ok = 0;
      act     = 1'b0;
      held_s  = '0;
      held_c  = 1'b0;
      held_o  = 1'b0;
    end else begin
      edge_cnt++;
      if (start && edge_cnt >= next_ok) begin
        q.push_back(model(a_in, b_in, cin, edge_cnt + W));
        act     = 1'b1;
        act_e0  = edge_cnt;
        next_ok = edge_cnt + W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bexp = act && (edge_cnt >= act_e0) && (edge_cnt < act_e0 + W);
      dexp = (q.size() > 0) && (q[0].due == edge_cnt);
      chk("busy", 32'(busy), 32'(bexp));
      chk("done", 32'(done), 32'(dexp));
      if (dexp) begin
        e      = q.pop_front();
        held_s = e.s;
        held_c = e.c;
        held_o = e.o;
      end
      chk("sum_out", 32'(sum_out), 32'(held_s));
      chk("cout_out", 32'(cout_out), 32'(held_c));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf_out", 32'(ovf_out), 32'(held_o));
`endif
      if (!bexp) chk("fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'(0));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_sum"}, 32'(sum_out), 32'(0));
    chk({tag, "_cout"}, 32'(cout_out), 32'(0));
    chk({tag, "_fa"}, 32'({fa_a, fa_b, fa_cin}), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf_out), 32'(0));
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    #1 rst_n = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0);
    drain();
    issue(8'hFF, 8'h01, 1'b0);
    drain();
    issue(8'hFF, 8'hFF, 1'b1);
    drain();
`ifdef SERIAL_ADDER_OVF_EN
    issue(8'h7F, 8'h01, 1'b0);
    drain();
    issue(8'h80, 8'hFF, 1'b0);
    drain();
`endif

    // Second request lands mid-SHIFT and must be dropped.
    issue(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'h01, 8'h01, 1'b0);
    drain();

    // Start held high: accepted in IDLE, then again from DONE.
    @(negedge clk);
    a_in  = 8'h11;
    b_in  = 8'h22;
    cin   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2 * (W + 1); i++) begin
      @(negedge clk);
      a_in = W'($urandom);
      b_in = W'($urandom);
      cin  = 1'($urandom);
    end
    start = 1'b0;
    drain();

    // Reset during the 4th SHIFT cycle aborts the operation.
    issue(8'hAA, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(8'h03, 8'h04, 1'b0);
    drain();

    for (int t = 0; t < 40; t++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      for (int g = 0; g < int'($urandom_range(12, 0)); g++) begin
        @(negedge clk);
        if ($urandom_range(3, 0) == 0) begin
          a_in  = W'($urandom);
          b_in  = W'($urandom);
          cin   = 1'($urandom);
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
